// File: rtl/pipe_id_operand_stage_pkg.sv
// Shared encodings for the ID operand stage: forward-select codes and the RUN/HOLD state type.
package pipe_id_operand_stage_pkg;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EALU = 2'b01;
   localparam logic [1:0] FWD_MALU = 2'b10;
   localparam logic [1:0] FWD_MMO  = 2'b11;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_id_operand_stage_fwd_mux4.sv
// DW-wide 4:1 operand mux driven by a forwarding select code.
module pipe_fwd_mux4
   import pipe_id_operand_stage_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    sel,
   input  logic [DW-1:0] d_rf,
   input  logic [DW-1:0] d_ealu,
   input  logic [DW-1:0] d_malu,
   input  logic [DW-1:0] d_mmo,
   output logic [DW-1:0] y
);

   // Select the operand source for the current ID instruction
   always_comb begin
      y = d_rf;
      case (sel)
         FWD_RF:   y = d_rf;
         FWD_EALU: y = d_ealu;
         FWD_MALU: y = d_malu;
         FWD_MMO:  y = d_mmo;
         default:  y = d_rf;
      endcase
   end

endmodule

// File: rtl/pipe_id_operand_stage.sv
// ID-stage operand forwarding, load-use stall control, RUN/HOLD freeze FSM,
// ID/EXE pipeline register bank and saturating stall counter.
module pipe_id_operand_stage
   import pipe_id_operand_stage_pkg::*;
#(
   parameter int DW   = 32,
   parameter int RW   = 5,
   parameter int CNTW = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      fwda,
   input  logic [1:0]      fwdb,
   input  logic [DW-1:0]   qa,
   input  logic [DW-1:0]   qb,
   input  logic [DW-1:0]   ealu,
   input  logic [DW-1:0]   malu,
   input  logic [DW-1:0]   mmo,
   input  logic [RW-1:0]   rs,
   input  logic [RW-1:0]   rt,
   input  logic            use_rs,
   input  logic            use_rt,
   input  logic            ewreg_i,
   input  logic            em2reg_i,
   input  logic [RW-1:0]   ern_i,
   input  logic            dwreg,
   input  logic            dm2reg,
   input  logic            dwmem,
   input  logic            daluimm,
   input  logic            dshift,
   input  logic            djal,
   input  logic [3:0]      daluc,
   input  logic [RW-1:0]   drn,
   input  logic [DW-1:0]   dimm,
   input  logic [DW-1:0]   dpc4,
   input  logic            kill,
   input  logic            mem_busy,
   output logic [DW-1:0]   da,
   output logic [DW-1:0]   db,
   output logic            wpcir,
   output logic            ewreg,
   output logic            em2reg,
   output logic            ewmem,
   output logic            ealuimm,
   output logic            eshift,
   output logic            ejal,
   output logic [3:0]      ealuc,
   output logic [RW-1:0]   ern,
   output logic [DW-1:0]   ea,
   output logic [DW-1:0]   eb,
   output logic [DW-1:0]   eimm,
   output logic [DW-1:0]   epc4,
   output logic [CNTW-1:0] stall_cnt,
   output logic            state
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   logic [DW-1:0]   da_s, db_s;
   logic            lu_s, wpcir_s, ex_load_s, ex_bubble_s, stall_s;
   state_t          state_r, state_next_s;
   logic            ewreg_r, em2reg_r, ewmem_r, ealuimm_r, eshift_r, ejal_r;
   logic [3:0]      ealuc_r;
   logic [RW-1:0]   ern_r;
   logic [DW-1:0]   ea_r, eb_r, eimm_r, epc4_r;
   logic [CNTW-1:0] stall_cnt_r;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   pipe_fwd_mux4 #(.DW(DW)) u_mux_a (
      .sel(fwda), .d_rf(qa), .d_ealu(ealu), .d_malu(malu), .d_mmo(mmo), .y(da_s)
   );

   pipe_fwd_mux4 #(.DW(DW)) u_mux_b (
      .sel(fwdb), .d_rf(qb), .d_ealu(ealu), .d_malu(malu), .d_mmo(mmo), .y(db_s)
   );

   // Hazard detection and next-state / register-bank control
   always_comb begin
      lu_s = ewreg_i & em2reg_i & (ern_i != {RW{1'b0}}) &
             ((use_rs & (ern_i == rs)) | (use_rt & (ern_i == rt)));
      state_next_s = state_r;
      wpcir_s      = 1'b1;
      ex_load_s    = 1'b1;
      ex_bubble_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (mem_busy) begin
               state_next_s = ST_HOLD;
               wpcir_s      = 1'b0;
               ex_load_s    = 1'b0;
            end else if (lu_s) begin
               // instruction stays in ID; EXE gets a bubble
               wpcir_s     = 1'b0;
               ex_bubble_s = 1'b1;
            end else if (kill) begin
               ex_bubble_s = 1'b1;
            end else begin
               ex_bubble_s = 1'b0;
            end
         end
         ST_HOLD: begin
            wpcir_s   = 1'b0;
            ex_load_s = 1'b0;
            if (mem_busy) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         default: begin
            state_next_s = ST_RUN;
            wpcir_s      = 1'b0;
            ex_load_s    = 1'b0;
         end
      endcase
      stall_s = ~wpcir_s;
   end

   // FSM state, ID/EXE register bank and stall counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RUN;
         ewreg_r     <= 1'b0;
         em2reg_r    <= 1'b0;
         ewmem_r     <= 1'b0;
         ealuimm_r   <= 1'b0;
         eshift_r    <= 1'b0;
         ejal_r      <= 1'b0;
         ealuc_r     <= 4'h0;
         ern_r       <= {RW{1'b0}};
         ea_r        <= {DW{1'b0}};
         eb_r        <= {DW{1'b0}};
         eimm_r      <= {DW{1'b0}};
         epc4_r      <= {DW{1'b0}};
         stall_cnt_r <= {CNTW{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (ex_load_s && ex_bubble_s) begin
            ewreg_r   <= 1'b0;
            em2reg_r  <= 1'b0;
            ewmem_r   <= 1'b0;
            ealuimm_r <= 1'b0;
            eshift_r  <= 1'b0;
            ejal_r    <= 1'b0;
            ealuc_r   <= 4'h0;
            ern_r     <= {RW{1'b0}};
            ea_r      <= {DW{1'b0}};
            eb_r      <= {DW{1'b0}};
            eimm_r    <= {DW{1'b0}};
            epc4_r    <= {DW{1'b0}};
         end else if (ex_load_s) begin
            ewreg_r   <= dwreg;
            em2reg_r  <= dm2reg;
            ewmem_r   <= dwmem;
            ealuimm_r <= daluimm;
            eshift_r  <= dshift;
            ejal_r    <= djal;
            ealuc_r   <= daluc;
            ern_r     <= drn;
            ea_r      <= da_s;
            eb_r      <= db_s;
            eimm_r    <= dimm;
            epc4_r    <= dpc4;
         end
         if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
      end
   end

   assign da        = da_s;
   assign db        = db_s;
   assign wpcir     = wpcir_s;
   assign ewreg     = ewreg_r;
   assign em2reg    = em2reg_r;
   assign ewmem     = ewmem_r;
   assign ealuimm   = ealuimm_r;
   assign eshift    = eshift_r;
   assign ejal      = ejal_r;
   assign ealuc     = ealuc_r;
   assign ern       = ern_r;
   assign ea        = ea_r;
   assign eb        = eb_r;
   assign eimm      = eimm_r;
   assign epc4      = epc4_r;
   assign stall_cnt = stall_cnt_r;
   assign state     = state_r;

endmodule
